// File: rtl/matrix_unit_scheduler_if.sv
// matrix_unit_scheduler_if
//   Bundles the requester handshake and the compute-unit control lines
//   of the matrix unit scheduler.
// Ports (signals)
//   req, ack     requester side: level request and result-captured ack
//   grant, done  one-hot owner and one-hot results-valid flag
//   sel          owner index for operand/result steering
//   err          one-cycle start/run timeout pulse
//   unit_en      enable to the shared compute unit
//   unit_busy    busy flag from the shared compute unit
// Modports
//   master  the scheduler (drives grant/done/sel/err/unit_en)
//   slave   the requesters and the unit (drive req/ack/unit_busy)
interface matrix_unit_scheduler_if #(
  parameter int NUM_REQ = 2
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [SEL_W-1:0]   sel;
  logic               err;
  logic               unit_en;
  logic               unit_busy;

  modport master (
    input  req, ack, unit_busy,
    output grant, done, sel, err, unit_en
  );

  modport slave (
    output req, ack, unit_busy,
    input  grant, done, sel, err, unit_en
  );
endinterface

// File: rtl/matrix_unit_scheduler.sv
// matrix_unit_scheduler
//   Shares one level-enabled matrix compute unit between NUM_REQ requesters.
//   Ownership is granted round-robin; unit_en is held while the owner reads
//   its results and is then dropped so the unit clears before the next owner.
// Ports
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    matrix_unit_scheduler_if.master: req/ack in, grant/done/sel/err out,
//          unit_en out to the unit, unit_busy in from the unit
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   START_WAIT  cycles allowed in START for unit_busy to rise
//   TIMEOUT     cycles allowed in RUN for unit_busy to fall
module matrix_unit_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int START_WAIT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  matrix_unit_scheduler_if.master  bus
);

  localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int START_W = $clog2(START_WAIT + 1);
  localparam int RUN_W   = $clog2(TIMEOUT + 1);

  localparam logic [START_W-1:0] START_LAST = START_W'(START_WAIT - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);
  localparam logic [SEL_W-1:0]   LAST_INIT  = SEL_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DONE,
    RELEASE,
    ERR
  } state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               err_q, err_d;
  logic               unit_en_q, unit_en_d;
  logic [SEL_W-1:0]   last_owner, last_owner_d;
  logic [START_W-1:0] start_cnt, start_cnt_d;
  logic [RUN_W-1:0]   run_cnt, run_cnt_d;
  logic               busy_q;

  logic               rr_found;
  logic [SEL_W-1:0]   rr_owner;
  logic               enter_err;

  // Round-robin pick: first requester after last_owner, wrapping around,
  // so the previous owner is only picked again when nobody else asks.
  always_comb begin : rr_scan
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_owner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_owner) + i) % NUM_REQ;
      if (!rr_found && bus.req[SEL_W'(idx)]) begin
        rr_found = 1'b1;
        rr_owner = SEL_W'(idx);
      end
    end
  end

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here describe the state being entered.
  always_comb begin
    state_d      = state;
    grant_d      = grant_q;
    done_d       = done_q;
    sel_d        = sel_q;
    err_d        = 1'b0;
    unit_en_d    = unit_en_q;
    last_owner_d = last_owner;
    start_cnt_d  = start_cnt;
    run_cnt_d    = run_cnt;
    enter_err    = 1'b0;

    case (state)
      IDLE: begin
        unit_en_d = 1'b0;
        if (rr_found) begin
          state_d     = START;
          grant_d     = ONE_HOT0 << rr_owner;
          sel_d       = rr_owner;
          unit_en_d   = 1'b1;
          start_cnt_d = '0;
        end
      end

      // Only a rising busy counts as a start, so a unit left busy from an
      // aborted operation cannot be mistaken for the new one.
      START: begin
        start_cnt_d = start_cnt + 1'b1;
        if (bus.unit_busy && !busy_q) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end else if (start_cnt == START_LAST) begin
          enter_err = 1'b1;
        end
      end

      RUN: begin
        run_cnt_d = run_cnt + 1'b1;
        if (!bus.unit_busy) begin
          state_d = DONE;
          done_d  = grant_q;
        end else if (run_cnt == RUN_LAST) begin
          enter_err = 1'b1;
        end
      end

      // unit_en stays high here so the unit keeps its results; a dropped
      // request is treated like an ack.
      DONE: begin
        if (bus.ack[sel_q] || !bus.req[sel_q]) begin
          state_d      = RELEASE;
          done_d       = '0;
          grant_d      = '0;
          unit_en_d    = 1'b0;
          last_owner_d = sel_q;
        end
      end

      RELEASE: state_d = IDLE;

      ERR: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (enter_err) begin
      state_d      = ERR;
      err_d        = 1'b1;
      unit_en_d    = 1'b0;
      grant_d      = '0;
      done_d       = '0;
      last_owner_d = sel_q;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      unit_en_q  <= 1'b0;
      last_owner <= LAST_INIT;
      start_cnt  <= '0;
      run_cnt    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      unit_en_q  <= unit_en_d;
      last_owner <= last_owner_d;
      start_cnt  <= start_cnt_d;
      run_cnt    <= run_cnt_d;
      busy_q     <= bus.unit_busy;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.sel     = sel_q;
  assign bus.err     = err_q;
  assign bus.unit_en = unit_en_q;

endmodule

// File: tb/tb_matrix_unit_scheduler.sv
// tb_matrix_unit_scheduler
//   Directed bench for matrix_unit_scheduler with two requesters,
//   START_WAIT=4 and TIMEOUT=8. A small unit model answers unit_en:
//   mode 0 = busy rises one cycle after en and stays high 5 cycles,
//   mode 1 = busy tied low, mode 2 = busy stuck high once started.
//   Busy always clears while en is low.
module tb_matrix_unit_scheduler;

  logic clk;
  logic reset;

  matrix_unit_scheduler_if #(.NUM_REQ(2)) bus ();

  matrix_unit_scheduler #(
    .NUM_REQ   (2),
    .START_WAIT(4),
    .TIMEOUT   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks   = 0;
  int cycle        = 0;
  int err_pulses   = 0;
  int unit_mode    = 0;
  logic       unit_fired;
  logic [3:0] busy_age;

  // Unit model
  always @(posedge clk) begin
    if (!bus.unit_en) begin
      bus.unit_busy <= 1'b0;
      unit_fired    <= 1'b0;
      busy_age      <= 4'd0;
    end else if (!unit_fired) begin
      unit_fired    <= 1'b1;
      bus.unit_busy <= (unit_mode != 1);
      busy_age      <= 4'd1;
    end else if (bus.unit_busy && unit_mode == 0) begin
      if (busy_age == 4'd5) bus.unit_busy <= 1'b0;
      else busy_age <= busy_age + 4'd1;
    end
  end

  always @(negedge clk) if (bus.err) err_pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] ack);
    bus.req = req;
    bus.ack = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic waitDone(input string tag);
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.done != 2'b00) break;
    end
    checkOutput(tag, {31'd0, bus.done != 2'b00}, 32'd1);
  endtask

  task automatic waitErr(input string tag, output logic done_seen);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.done != 2'b00) done_seen = 1'b1;
      if (bus.err) break;
    end
    checkOutput(tag, {31'd0, bus.err}, 32'd1);
  endtask

  initial begin
    int start_cycle;
    int low_cnt;
    logic found;
    logic done_seen;
    logic [1:0] exp_grant;

    bus.unit_busy = 1'b0;
    unit_fired    = 1'b0;
    busy_age      = 4'd0;
    applyStimulus(2'b00, 2'b00);
    reset = 1'b1;
    step();
    step();

    // Reset state
    checkOutput("rst_grant", bus.grant, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_sel", bus.sel, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_en", bus.unit_en, 0);
    reset = 1'b0;
    step();

    // 1 Single request, with stray acks outside DONE and from a non-owner
    applyStimulus(2'b01, 2'b00);
    step();
    start_cycle = cycle;
    checkOutput("t1_grant", bus.grant, 2'b01);
    checkOutput("t1_sel", bus.sel, 0);
    checkOutput("t1_en", bus.unit_en, 1);
    step();
    step();
    applyStimulus(2'b01, 2'b01);
    step();
    applyStimulus(2'b01, 2'b00);
    waitDone("t1_done_seen");
    checkOutput("t1_done_cycle", cycle - start_cycle, 7);
    checkOutput("t1_done", bus.done, 2'b01);
    checkOutput("t1_done_en", bus.unit_en, 1);
    applyStimulus(2'b01, 2'b10);
    step();
    checkOutput("t1_nonowner_ack_done", bus.done, 2'b01);
    checkOutput("t1_nonowner_ack_grant", bus.grant, 2'b01);
    applyStimulus(2'b01, 2'b01);
    step();
    checkOutput("t1_rel_done", bus.done, 0);
    checkOutput("t1_rel_grant", bus.grant, 0);
    checkOutput("t1_rel_en", bus.unit_en, 0);
    applyStimulus(2'b00, 2'b00);
    step();
    checkOutput("t1_idle_en", bus.unit_en, 0);
    checkOutput("t1_idle_grant", bus.grant, 0);
    checkOutput("t1_err_count", err_pulses, 0);

    // 2 Contention after a fresh reset: 01,10,01,10
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(2'b11, 2'b00);
    low_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (bus.grant != 2'b00) begin
          found = 1'b1;
          break;
        end
        if (!bus.unit_en) low_cnt++;
      end
      checkOutput($sformatf("t2_grant_seen%0d", k), {31'd0, found}, 1);
      checkOutput($sformatf("t2_grant%0d", k), bus.grant, exp_grant);
      if (k > 0) checkOutput($sformatf("t2_en_gap%0d", k), {31'd0, low_cnt >= 2}, 1);
      waitDone($sformatf("t2_done_seen%0d", k));
      checkOutput($sformatf("t2_done%0d", k), bus.done, exp_grant);
      applyStimulus(2'b11, exp_grant);
      step();
      applyStimulus((k == 3) ? 2'b00 : 2'b11, 2'b00);
      checkOutput($sformatf("t2_rel_en%0d", k), bus.unit_en, 0);
      low_cnt = 1;
    end
    step();

    // 3 Start timeout
    unit_mode = 1;
    applyStimulus(2'b01, 2'b00);
    step();
    start_cycle = cycle;
    checkOutput("t3_grant", bus.grant, 2'b01);
    waitErr("t3_err_seen", done_seen);
    checkOutput("t3_err_cycle", cycle - start_cycle, 4);
    checkOutput("t3_err_grant", bus.grant, 0);
    checkOutput("t3_err_en", bus.unit_en, 0);
    applyStimulus(2'b00, 2'b00);
    step();
    checkOutput("t3_err_pulse", bus.err, 0);
    checkOutput("t3_next_grant", bus.grant, 0);
    checkOutput("t3_err_count", err_pulses, 1);

    // 4 Run timeout
    unit_mode = 2;
    applyStimulus(2'b01, 2'b00);
    step();
    start_cycle = cycle;
    waitErr("t4_err_seen", done_seen);
    checkOutput("t4_err_cycle", cycle - start_cycle, 10);
    checkOutput("t4_no_done", {31'd0, done_seen}, 0);
    checkOutput("t4_err_en", bus.unit_en, 0);
    checkOutput("t4_err_grant", bus.grant, 0);
    applyStimulus(2'b00, 2'b00);
    unit_mode = 0;
    step();
    checkOutput("t4_err_count", err_pulses, 2);

    // 5 Requester withdraws during RUN
    applyStimulus(2'b01, 2'b00);
    step();
    start_cycle = cycle;
    step();
    step();
    applyStimulus(2'b00, 2'b00);
    waitDone("t5_done_seen");
    checkOutput("t5_done_cycle", cycle - start_cycle, 7);
    checkOutput("t5_done", bus.done, 2'b01);
    step();
    checkOutput("t5_done_pulse", bus.done, 0);
    checkOutput("t5_rel_grant", bus.grant, 0);
    checkOutput("t5_rel_en", bus.unit_en, 0);
    step();

    // 6 Reset mid-RUN, then round-robin restarts at requester 0
    applyStimulus(2'b11, 2'b00);
    step();
    checkOutput("t6_grant", bus.grant, 2'b10);
    checkOutput("t6_sel", bus.sel, 1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("t6_rst_grant", bus.grant, 0);
    checkOutput("t6_rst_done", bus.done, 0);
    checkOutput("t6_rst_sel", bus.sel, 0);
    checkOutput("t6_rst_err", bus.err, 0);
    checkOutput("t6_rst_en", bus.unit_en, 0);
    step();
    checkOutput("t6_regrant", bus.grant, 2'b01);
    checkOutput("t6_regrant_sel", bus.sel, 0);
    checkOutput("t6_regrant_en", bus.unit_en, 1);
    applyStimulus(2'b00, 2'b00);
    step();
    checkOutput("t6_err_count", err_pulses, 2);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
